// File: rtl/echo_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : echo_sequencer
// Description : Stereo echo engine. Each sample runs through a six-state
//               sequence that reads the delayed L/R samples from a shared
//               single-port RAM, writes the new samples, and outputs a
//               saturated dry + attenuated echo mix.
// Revision    : 1.0 - initial release
// ============================================================================
module echo_sequencer #(
    parameter int AW            = 10,
    parameter int DEFAULT_DELAY = 512
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic [15:0]   audio_l_in,
    input  logic [15:0]   audio_r_in,
    input  logic [AW-1:0] cfg_delay,
    input  logic [1:0]    cfg_shift,
    input  logic          cfg_enable,
    input  logic          cfg_load,
    output logic [AW:0]   mem_addr,
    output logic          mem_we,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    output logic [15:0]   audio_l_out,
    output logic [15:0]   audio_r_out,
    output logic          out_valid,
    output logic          busy,
    output logic          overrun
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RD_L = 3'd1;
    localparam logic [2:0] c_RD_R = 3'd2;
    localparam logic [2:0] c_WR_L = 3'd3;
    localparam logic [2:0] c_WR_R = 3'd4;
    localparam logic [2:0] c_MIX  = 3'd5;

    localparam logic [AW:0]   c_FILL_MAX  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   c_FILL_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] c_PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] c_DLY_RESET = AW'(DEFAULT_DELAY);

    logic [2:0]    r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_fill;
    logic [AW-1:0] r_delay;
    logic [1:0]    r_shift;
    logic          r_en;
    logic          r_pend;
    logic [AW-1:0] r_pend_delay;
    logic [1:0]    r_pend_shift;
    logic          r_pend_en;
    logic [15:0]   r_lat_l;
    logic [15:0]   r_lat_r;
    logic [15:0]   r_dly_l;
    logic [15:0]   r_dly_r;
    logic          r_echo_ok;

    logic [AW-1:0] w_new_delay;
    logic [AW:0]   w_new_eff;
    logic [AW-1:0] w_new_rd;
    logic [15:0]   w_mix_l;
    logic [15:0]   w_mix_r;

    assign busy = (r_state != c_IDLE);

    // Dry + (delayed >>> (shift+1)), saturated to 16 bits; bypass returns dry.
    function automatic logic [15:0] f_mix(input logic [15:0] dry, input logic [15:0] dly,
                                          input logic ok, input logic [1:0] shift,
                                          input logic en);
        logic signed [15:0] v_dly;
        logic signed [15:0] v_echo;
        logic [2:0]         v_sh;
        logic [16:0]        v_sum;
        logic [15:0]        v_res;
        v_dly  = ok ? dly : 16'sd0;
        v_sh   = {1'b0, shift} + 3'd1;
        v_echo = v_dly >>> v_sh;
        v_sum  = {dry[15], dry} + {v_echo[15], v_echo};
        case (v_sum[16:15])
            2'b01:   v_res = 16'h7FFF;
            2'b10:   v_res = 16'h8000;
            default: v_res = v_sum[15:0];
        endcase
        if (!en) v_res = dry;
        return v_res;
    endfunction

    // Config seen by a sample accepted this cycle, and its read pointer / fill guard.
    always_comb begin
        w_new_delay = cfg_load ? cfg_delay : r_delay;
        w_new_eff   = (w_new_delay == '0) ? c_FILL_MAX : {1'b0, w_new_delay};
        w_new_rd    = r_wr_ptr - w_new_delay;
        w_mix_l     = f_mix(r_lat_l, r_dly_l, r_echo_ok, r_shift, r_en);
        w_mix_r     = f_mix(r_lat_r, r_dly_r, r_echo_ok, r_shift, r_en);
    end

    // Sequencer: RAM access, pointer/fill bookkeeping, config handling, output mix.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill       <= '0;
            r_delay      <= c_DLY_RESET;
            r_shift      <= 2'd0;
            r_en         <= 1'b1;
            r_pend       <= 1'b0;
            r_pend_delay <= '0;
            r_pend_shift <= 2'd0;
            r_pend_en    <= 1'b0;
            r_lat_l      <= '0;
            r_lat_r      <= '0;
            r_dly_l      <= '0;
            r_dly_r      <= '0;
            r_echo_ok    <= 1'b0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            audio_l_out  <= '0;
            audio_r_out  <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (sample_valid && r_state != c_IDLE) overrun <= 1'b1;
            // Config arriving mid-sequence waits until the sequence ends.
            if (cfg_load && r_state != c_IDLE && r_state != c_MIX) begin
                r_pend       <= 1'b1;
                r_pend_delay <= cfg_delay;
                r_pend_shift <= cfg_shift;
                r_pend_en    <= cfg_enable;
            end
            case (r_state)
                c_IDLE: begin
                    if (cfg_load) begin
                        r_delay <= cfg_delay;
                        r_shift <= cfg_shift;
                        r_en    <= cfg_enable;
                    end
                    if (sample_valid) begin
                        r_lat_l   <= audio_l_in;
                        r_lat_r   <= audio_r_in;
                        r_rd_ptr  <= w_new_rd;
                        r_echo_ok <= (r_fill >= w_new_eff);
                        mem_addr  <= {1'b0, w_new_rd};
                        mem_we    <= 1'b0;
                        r_state   <= c_RD_L;
                    end
                end
                c_RD_L: begin
                    mem_addr <= {1'b1, r_rd_ptr};
                    r_state  <= c_RD_R;
                end
                c_RD_R: begin
                    r_dly_l   <= mem_rdata;
                    mem_addr  <= {1'b0, r_wr_ptr};
                    mem_we    <= 1'b1;
                    mem_wdata <= r_lat_l;
                    r_state   <= c_WR_L;
                end
                c_WR_L: begin
                    r_dly_r   <= mem_rdata;
                    mem_addr  <= {1'b1, r_wr_ptr};
                    mem_we    <= 1'b1;
                    mem_wdata <= r_lat_r;
                    r_state   <= c_WR_R;
                end
                c_WR_R: begin
                    mem_we   <= 1'b0;
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                    if (r_fill != c_FILL_MAX) r_fill <= r_fill + c_FILL_ONE;
                    r_state  <= c_MIX;
                end
                c_MIX: begin
                    audio_l_out <= w_mix_l;
                    audio_r_out <= w_mix_r;
                    out_valid   <= 1'b1;
                    // A load in this very cycle supersedes any pending one.
                    if (cfg_load) begin
                        r_delay <= cfg_delay;
                        r_shift <= cfg_shift;
                        r_en    <= cfg_enable;
                    end else if (r_pend) begin
                        r_delay <= r_pend_delay;
                        r_shift <= r_pend_shift;
                        r_en    <= r_pend_en;
                    end
                    r_pend  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/echo_sequencer.md
ECHO_SEQUENCER -- requirements
Module: echo_sequencer

Interface
REQ-001 Parameter AW, 10, delay-line pointer width; depth per channel = 2^AW = 1024 samples.
REQ-002 Parameter DEFAULT_DELAY, 512, active delay after reset.
REQ-003 Port clk  in  1  single clock; all logic on rising edge.
REQ-004 Port rst  in  1  synchronous, active-high reset.
REQ-005 Port sample_valid  in  1  one-cycle strobe; new stereo sample present.
REQ-006 Port audio_l_in, audio_r_in  in  16 each  signed two's-complement samples.
REQ-007 Port cfg_delay  in  AW  requested delay in samples; 0 means 1024.
REQ-008 Port cfg_shift  in  2  echo attenuation; echo = delayed >>> (cfg_shift+1).
REQ-009 Port cfg_enable  in  1  1 = mix echo, 0 = dry bypass.
REQ-010 Port cfg_load  in  1  one-cycle strobe; apply cfg_* to active config.
REQ-011 Port mem_addr  out  AW+1  shared single-port RAM address {channel, pointer}; channel 0 = L, 1 = R.
REQ-012 Port mem_we  out  1  RAM write enable.
REQ-013 Port mem_wdata  out  16  RAM write data.
REQ-014 Port mem_rdata  in  16  RAM read data, valid one cycle after the read address.
REQ-015 Port audio_l_out, audio_r_out  out  16 each  registered, signed, saturated mix.
REQ-016 Port out_valid  out  1  one-cycle pulse; outputs updated.
REQ-017 Port busy  out  1  high in every state except IDLE.
REQ-018 Port overrun  out  1  sticky; sample_valid dropped while busy.

Function
REQ-019 FSM states: IDLE, RD_L, RD_R, WR_L, WR_R, MIX; each non-IDLE state lasts exactly one cycle, in that order, then IDLE.
REQ-020 IDLE with sample_valid=1: latch both inputs, go to RD_L; otherwise stay in IDLE.
REQ-021 Read pointer rd = (wr_ptr - active_delay) mod 1024; RD_L drives mem_addr={0,rd}, RD_R drives {1,rd}, mem_we=0.
REQ-022 RD_R captures mem_rdata as dly_l; WR_L captures mem_rdata as dly_r.
REQ-023 WR_L writes the latched L to {0,wr_ptr}; WR_R writes the latched R to {1,wr_ptr}; mem_we=1 only in WR_L and WR_R.
REQ-024 wr_ptr increments by 1 in WR_R, wrapping 1023 -> 0.
REQ-025 Delay 0 gives rd = wr_ptr: the read precedes the write, so the echo lags by exactly 1024 samples.
REQ-026 Fill guard: fill_cnt (11 bits) counts completed WR_R states and saturates at 1024; if fill_cnt < effective delay (cfg 0 counts as 1024), the delayed terms are forced to 0.
REQ-027 MIX computes a 17-bit sum = sign-extended input + (delayed >>> (shift+1)), using an arithmetic shift.
REQ-028 Saturation: sum > 32767 -> 32767; sum < -32768 -> -32768; otherwise truncate to 16 bits.
REQ-029 Bypass: if active enable=0, the output equals the latched input; RAM writes and the pointer still advance.
REQ-030 MIX registers both outputs; out_valid=1 for that one edge, so out_valid rises 6 cycles after the accepted sample_valid cycle.
REQ-031 Outputs hold their value between out_valid pulses.
REQ-032 sample_valid while busy=1: the sample is discarded, overrun is set, and the sequence in flight is unaffected.
REQ-033 cfg_load in IDLE updates the active delay, shift and enable at the end of that cycle; a sample accepted in the same cycle uses the new config.
REQ-034 cfg_load while busy: the config is captured and flagged pending, then applied on the cycle the FSM re-enters IDLE; a later cfg_load overwrites the pending value.
REQ-035 Throughput: at most one sample per 6 cycles; back-to-back acceptance is allowed on the cycle after MIX.

Reset
REQ-036 rst=1 at an edge, including mid-sequence: state=IDLE, wr_ptr=0, fill_cnt=0, pending=0, outputs=0, out_valid=0, busy=0, overrun=0, mem_we=0, mem_addr=0.
REQ-037 Active config after reset: delay=DEFAULT_DELAY, shift=0, enable=1; RAM contents are not cleared, and the fill guard masks them.
REQ-038 A sequence interrupted by reset produces no out_valid.

Verification
REQ-039 Reset; load delay=4, shift=0; L: 1000 then zeros -> L out samples 0..4 = 1000, 0, 0, 0, 500; R out all 0.
REQ-040 delay=1, shift=0, L=30000 constant -> sample0=30000, sample1 onward=32767; L=-30000 -> -32768.
REQ-041 sample_valid at cycle 0 and cycle 2 -> one out_valid at cycle 6, overrun=1, wr_ptr advances by 1.
REQ-042 enable=0, ramp input -> outputs equal inputs; a switch to enable=1 echoes the ramp written during bypass.
REQ-043 cfg_load of delay=8 at cycle 3 of a sequence -> that sample uses the old delay, the next sample uses 8.
REQ-044 delay=0, impulse 2000 -> echo 1000 appears exactly at sample 1024; reset asserted at cycle 3 of a sequence -> no out_valid, wr_ptr=0.
